// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith permutation sequencer and its helpers.
package monolith_pkg;

  localparam int MONOLITH_NUM_ROUNDS = 6;
  localparam logic [30:0] M31_PRIME = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    LAYER_CONCRETE = 2'd0,
    LAYER_BARS     = 2'd1,
    LAYER_BRICKS   = 2'd2
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } fsm_e;

  // Layer for position (k-1)%3 inside a full round.
  function automatic layer_e phase_layer(input int phase);
    case (phase)
      0:       return LAYER_BARS;
      1:       return LAYER_BRICKS;
      default: return LAYER_CONCRETE;
    endcase
  endfunction

endpackage

// File: rtl/monolith_layer_watchdog.sv
// Cycle watchdog for an outstanding layer request; expired is combinational and fires
// in the enabled cycle whose increment would reach TIMEOUT.
module monolith_layer_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/monolith_round_sequencer.sv
// Issues the Monolith layer schedule (concrete, then rounds of bars/bricks/concrete) to external
// layer units; one layer per L+1 cycles, result held on out_valid until out_ready.
module monolith_round_sequencer
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16,
  parameter int NUM_ROUNDS = MONOLITH_NUM_ROUNDS,
  parameter int TIMEOUT    = 255
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [0:STATE_SIZE-1][WORD_WIDTH-1:0]        state_in,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [0:STATE_SIZE-1][WORD_WIDTH-1:0]        state_out,
  output logic [1:0]                                   layer_sel,
  output logic                                         layer_in_valid,
  output logic                                         layer_rc_en,
  output logic [$clog2(NUM_ROUNDS)-1:0]                layer_rc_idx,
  input  logic [0:STATE_SIZE-1][WORD_WIDTH-1:0]        layer_state_in,
  input  logic                                         layer_out_valid,
  output logic                                         err
);

  localparam int LAST_K = 3 * NUM_ROUNDS;
  localparam int K_W    = $clog2(LAST_K + 1);
  localparam int RC_W   = $clog2(NUM_ROUNDS);

  fsm_e state_q, state_nxt;
  logic [K_W-1:0] k_q;
  logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] st_q;

  logic load, capture, last_k;
  logic wd_clear, wd_en, wd_expired;
  int   k_int, round_int, phase_int;

  monolith_layer_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign last_k    = (k_q == K_W'(LAST_K));
  assign state_out = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        st_q <= state_in;
        k_q  <= '0;
      end
      if (capture) begin
        st_q <= layer_state_in;
        if (!last_k) k_q <= k_q + 1'b1;
      end
    end
  end

  // Schedule decode: k=0 is the lone initial concrete layer, then triples per round.
  always_comb begin
    k_int     = int'(k_q);
    round_int = 0;
    phase_int = 2;
    if (k_int != 0) begin
      round_int = (k_int - 1) / 3;
      phase_int = (k_int - 1) % 3;
    end
    layer_sel    = phase_layer(phase_int);
    layer_rc_en  = (k_int != 0) && (phase_int == 2) && (round_int < NUM_ROUNDS - 1);
    layer_rc_idx = RC_W'(round_int);
  end

  always_comb begin
    state_nxt      = state_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    layer_in_valid = 1'b0;
    err            = 1'b0;
    load           = 1'b0;
    capture        = 1'b0;
    wd_clear       = 1'b1;
    wd_en          = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        layer_in_valid = 1'b1;
        wd_clear       = 1'b0;
        wd_en          = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        wd_clear = 1'b0;
        wd_en    = 1'b1;
        // A result landing in the expiry cycle still counts.
        if (layer_out_valid) begin
          capture   = 1'b1;
          wd_clear  = 1'b1;
          state_nxt = last_k ? S_DONE : S_ISSUE;
        end else if (wd_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_monolith_round_sequencer.sv
// Bench for monolith_round_sequencer: behavioural layer model plus reference permutation.
module tb_monolith_round_sequencer;

  typedef logic [0:15][30:0] st_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  st_t        state_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  st_t        state_out;
  logic [1:0] layer_sel;
  logic       layer_in_valid;
  logic       layer_rc_en;
  logic [2:0] layer_rc_idx;
  st_t        layer_state_in = '0;
  logic       layer_out_valid = 1'b0;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // layer model configuration (written by the stimulus block only)
  int lat_cfg = 3;
  int mode_cfg = 0;
  int gen = 0;
  bit resp_en = 1'b1;

  // layer model state (written by the model process only)
  int seen_gen = 0;
  int issue_cnt = 0;
  int last_issue_cyc = 0;
  bit pend = 1'b0;
  int due = 0;
  st_t pend_dat = '0;
  int sel_log [64];
  int rce_log [64];
  int rci_log [64];

  int exp_sel [19];
  int exp_rce [19];
  int exp_rci [19];

  monolith_round_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .state_in        (state_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .state_out       (state_out),
    .layer_sel       (layer_sel),
    .layer_in_valid  (layer_in_valid),
    .layer_rc_en     (layer_rc_en),
    .layer_rc_idx    (layer_rc_idx),
    .layer_state_in  (layer_state_in),
    .layer_out_valid (layer_out_valid),
    .err             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode 0: XOR (n+1) into word 0. Mode 1: rotate words left by one, then XOR (n+1) into word 0.
  function automatic st_t layer_fn(input st_t s, input int n, input int mode);
    st_t r = s;
    if (mode == 1) for (int i = 0; i < 16; i++) r[i] = s[(i + 1) % 16];
    r[0] = r[0] ^ 31'(n + 1);
    return r;
  endfunction

  function automatic st_t ref_perm(input st_t s, input int mode);
    st_t r = s;
    for (int n = 0; n < 19; n++) r = layer_fn(r, n, mode);
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int i = 0; i < 16; i++) r[i] = 31'($urandom);
    return r;
  endfunction

  // Layer unit model: answers each issue lat_cfg cycles later with layer_fn of the issued state.
  always @(posedge clk) begin
    #1;
    if (gen != seen_gen) begin
      seen_gen = gen;
      issue_cnt = 0;
    end
    if (pend && cyc == due) begin
      layer_out_valid = 1'b1;
      layer_state_in  = pend_dat;
      pend = 1'b0;
    end else begin
      layer_out_valid = 1'b0;
    end
    if (layer_in_valid) begin
      if (issue_cnt < 64) begin
        sel_log[issue_cnt] = int'(layer_sel);
        rce_log[issue_cnt] = int'(layer_rc_en);
        rci_log[issue_cnt] = int'(layer_rc_idx);
      end
      if (resp_en) begin
        pend = 1'b1;
        due = cyc + lat_cfg;
        pend_dat = layer_fn(state_out, issue_cnt, mode_cfg);
      end
      last_issue_cyc = cyc;
      issue_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_perm(input st_t st, input int lat, input int mode, input int hold);
    st_t exp;
    int hs, guard;
    lat_cfg = lat;
    mode_cfg = mode;
    resp_en = 1'b1;
    gen++;
    exp = ref_perm(st, mode);
    chk("in_ready_before_load", in_ready, 1);
    state_in = st;
    in_valid = 1'b1;
    hs = cyc;
    tick();
    in_valid = 1'b0;
    state_in = rand_state();
    guard = 0;
    while (!out_valid && guard < 2000) begin
      tick();
      guard++;
    end
    chk("out_valid_timeout", out_valid, 1);
    chk("latency", cyc - hs, 19 * (lat + 1) + 1);
    chk("state_out", state_out, exp);
    chk("issue_count", issue_cnt, 19);
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("layer_sel[%0d]", i), sel_log[i], exp_sel[i]);
      chk($sformatf("rc_en[%0d]", i), rce_log[i], exp_rce[i]);
      chk($sformatf("rc_idx[%0d]", i), rci_log[i], exp_rci[i]);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 3 == 1);
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_state_out", state_out, exp);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("after_hs_out_valid", out_valid, 0);
    chk("after_hs_in_ready", in_ready, 1);
    tick();
    chk("after_hs_no_issue", layer_in_valid, 0);
  endtask

  initial begin
    int idx, guard, ic, e_cyc;
    idx = 1;
    exp_sel[0] = 0; exp_rce[0] = 0; exp_rci[0] = 0;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 3; p++) begin
        exp_sel[idx] = (p == 0) ? 1 : (p == 1) ? 2 : 0;
        exp_rce[idx] = (p == 2 && r < 5) ? 1 : 0;
        exp_rci[idx] = r;
        idx++;
      end
    end

    // reset and idle
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_err", err, 0);
      chk("idle_layer_in_valid", layer_in_valid, 0);
    end
    chk("reset_state_out", state_out, 0);
    chk("reset_layer_sel", layer_sel, 0);
    chk("reset_rc_en", layer_rc_en, 0);
    chk("reset_rc_idx", layer_rc_idx, 0);

    // directed all-zero run, L=3, with 10 cycles of backpressure
    run_perm('0, 3, 0, 10);

    // randomized permutations
    for (int t = 0; t < 4; t++) run_perm(rand_state(), $urandom_range(1, 4), 1, $urandom_range(0, 3));

    // reset during the WAIT of a round-3 layer, stale result arrives afterwards
    lat_cfg = 4;
    mode_cfg = 1;
    resp_en = 1'b1;
    gen++;
    state_in = rand_state();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (issue_cnt < 11 && guard < 500) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("mid_reset_reach_round3", issue_cnt, 11);
    chk("mid_reset_pending", pend, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stale_in_ready", in_ready, 1);
      chk("stale_layer_in_valid", layer_in_valid, 0);
      chk("stale_state_out", state_out, 0);
      chk("stale_err", err, 0);
    end
    chk("stale_delivered", pend, 0);
    run_perm(rand_state(), 2, 1, 1);

    // layer never answers: watchdog expiry
    resp_en = 1'b0;
    gen++;
    state_in = rand_state();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (issue_cnt < 1 && guard < 20) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("noresp_issued", issue_cnt, 1);
    ic = last_issue_cyc;
    e_cyc = -1;
    guard = 0;
    while (e_cyc < 0 && guard < 400) begin
      @(posedge clk);
      #1;
      if (err) e_cyc = cyc;
      guard++;
    end
    chk("err_delay", e_cyc - ic, 255);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      chk("err_sticky", err, 1);
      chk("err_out_valid", out_valid, 0);
      chk("err_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("err_cleared", err, 0);
    chk("post_err_in_ready", in_ready, 1);
    run_perm(rand_state(), 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
